imem_dump_tx: RTL and testbench

- UART transmit-side counterpart of the CPU program loader.
- Reads N 16-bit words from instruction memory through a synchronous read port. Serialises them with the loader's framing: count LSB, count MSB, then each word as LSB then MSB.
- Each byte is sent as an 8N1 UART frame.
- Sits beside InstructionMemory at the top level for program readback and verification.

---
 rtl/imem_dump_tx_pkg.sv | 44 ++++
 rtl/imem_dump_tx_uart_tx_byte.sv | 60 ++++++
 rtl/imem_dump_tx.sv | 161 ++++++++++++++++
 tb/tb_imem_dump_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dump_tx_pkg.sv
// rtl/imem_dump_tx_pkg.sv - shared state encoding, UART frame constants and dump framing order
package imem_dump_tx_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_LSB,
        ST_CNT_MSB,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_W_LSB,
        ST_W_MSB,
`ifdef DUMP_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_FIN
    } dump_state_e;

    // Byte order on the wire, shared with the loader's receive side
    typedef enum logic [1:0] {
        FRM_CNT_LSB,
        FRM_CNT_MSB,
        FRM_W_LSB,
        FRM_W_MSB
    } frame_slot_e;

    function automatic logic [7:0] frame_byte(input frame_slot_e slot,
                                              input logic [15:0] cnt,
                                              input logic [15:0] word);
        logic [7:0] b;
        case (slot)
            FRM_CNT_LSB: b = cnt[7:0];
            FRM_CNT_MSB: b = cnt[15:8];
            FRM_W_LSB:   b = word[7:0];
            FRM_W_MSB:   b = word[15:8];
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_dump_tx_uart_tx_byte.sv
// rtl/imem_dump_tx_uart_tx_byte.sv - 8N1 byte serializer, one bit per BAUD_CNT clocks
module uart_tx_byte
    import imem_dump_tx_pkg::*;
#(
    parameter int BAUD_CNT = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       tx_go,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_pin
);

    localparam int             CW        = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(DATA_BITS + 1);

    logic          busy_q;
    logic          pin_q;
    logic [CW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [7:0]    shift_q;

    // Bit 0 is the start bit, 1..8 data, 9 stop; the shifter back-fills stop bits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_q  <= 1'b0;
            pin_q   <= STOP_BIT;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else if (!busy_q) begin
            pin_q <= STOP_BIT;
            if (tx_go) begin
                busy_q  <= 1'b1;
                pin_q   <= START_BIT;
                shift_q <= tx_data;
                baud_q  <= '0;
                bit_q   <= '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == LAST_BIT) begin
                busy_q <= 1'b0;
                pin_q  <= STOP_BIT;
            end else begin
                bit_q   <= bit_q + 4'd1;
                pin_q   <= shift_q[0];
                shift_q <= {STOP_BIT, shift_q[7:1]};
            end
        end else begin
            baud_q <= baud_q + 1'b1;
        end
    end

    assign tx_busy = busy_q;
    assign tx_pin  = pin_q;

endmodule

// File: rtl/imem_dump_tx.sv
// rtl/imem_dump_tx.sv - instruction memory dump over UART; DUMP_CHECKSUM_EN appends a byte-sum frame
module imem_dump_tx
    import imem_dump_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] word_count,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        uart_tx_pin,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;

    dump_state_e state_q;
    logic [15:0] cnt_q;
    logic [15:0] addr_q;
    logic [15:0] sent_q;
    logic [15:0] word_q;
    logic [7:0]  tx_data_q;
    logic        tx_go_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_en_q;
    logic        tx_busy;
    logic        tx_accept;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    assign tx_accept = tx_go_q & ~tx_busy;

    // Dump sequencer: header, then fetch/send each word, then wait for the line to drain
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            sent_q    <= '0;
            word_q    <= '0;
            tx_data_q <= '0;
            tx_go_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    cnt_q     <= word_count;
                    addr_q    <= '0;
                    sent_q    <= '0;
                    busy_q    <= 1'b1;
                    tx_go_q   <= 1'b1;
                    tx_data_q <= frame_byte(FRM_CNT_LSB, word_count, word_q);
`ifdef DUMP_CHECKSUM_EN
                    sum_q     <= '0;
`endif
                    state_q   <= ST_CNT_LSB;
                end
                ST_CNT_LSB: if (tx_accept) begin
                    tx_data_q <= frame_byte(FRM_CNT_MSB, cnt_q, word_q);
                    state_q   <= ST_CNT_MSB;
                end
                ST_CNT_MSB: if (tx_accept) begin
                    if (cnt_q != 16'd0) begin
                        tx_go_q <= 1'b0;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        tx_data_q <= 8'h00;
                        state_q   <= ST_CKSUM;
`else
                        tx_go_q   <= 1'b0;
                        state_q   <= ST_FIN;
`endif
                    end
                end
                ST_FETCH: state_q <= ST_FETCH_WAIT;
                ST_FETCH_WAIT: begin
                    word_q    <= mem_rdata;
                    tx_data_q <= frame_byte(FRM_W_LSB, cnt_q, mem_rdata);
                    tx_go_q   <= 1'b1;
                    state_q   <= ST_W_LSB;
                end
                ST_W_LSB: if (tx_accept) begin
                    tx_data_q <= frame_byte(FRM_W_MSB, cnt_q, word_q);
`ifdef DUMP_CHECKSUM_EN
                    sum_q     <= sum_q + word_q[7:0];
`endif
                    state_q   <= ST_W_MSB;
                end
                ST_W_MSB: if (tx_accept) begin
                    sent_q <= sent_q + 16'd1;
                    addr_q <= addr_q + 16'd1;
                    if ((sent_q + 16'd1) == cnt_q) begin
`ifdef DUMP_CHECKSUM_EN
                        tx_data_q <= sum_q + word_q[15:8];
                        state_q   <= ST_CKSUM;
`else
                        tx_go_q   <= 1'b0;
                        state_q   <= ST_FIN;
`endif
                    end else begin
                        tx_go_q <= 1'b0;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end
`ifdef DUMP_CHECKSUM_EN
                    sum_q <= sum_q + word_q[15:8];
`endif
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CKSUM: if (tx_accept) begin
                    tx_go_q <= 1'b0;
                    state_q <= ST_FIN;
                end
`endif
                // busy stays high through the done cycle so a coincident start is ignored
                ST_FIN: begin
                    if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!tx_busy && !tx_go_q) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_CNT (BAUD_CNT)
    ) u_tx (
        .CLK     (CLK),
        .RESET   (RESET),
        .tx_go   (tx_go_q),
        .tx_data (tx_data_q),
        .tx_busy (tx_busy),
        .tx_pin  (uart_tx_pin)
    );

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_imem_dump_tx.sv
// tb/tb_imem_dump_tx.sv - randomized self-checking bench with a UART receive monitor and stream model
`timescale 1ns/1ps
module tb_imem_dump_tx;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = 16'h0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic        uart_tx_pin;
    logic        busy;
    logic        done;

    imem_dump_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .word_count  (word_count),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .uart_tx_pin (uart_tx_pin),
        .busy        (busy),
        .done        (done)
    );

    always #500 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] mem [16];
    always @(posedge CLK) if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];

    int          cyc = 0;
    always @(posedge CLK) cyc++;

    logic [7:0]  rx_q [$];
    logic [15:0] rd_q [$];
    int          done_cnt = 0;
    int          frame_err = 0;
    int          last_fall = -1;
    int          max_per = 0;
    int          min_per = 1000000;

    always @(negedge CLK) if (RESET && mem_rd_en) rd_q.push_back(mem_addr);
    always @(negedge CLK) if (RESET && done) done_cnt++;

    task automatic mon_wait(input int n, inout bit ok);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (!RESET) ok = 1'b0;
        end
    endtask

    // Behavioural 8N1 receiver sampling mid-bit; aborts a frame if reset is seen
    bit         mon_ok;
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET && uart_tx_pin === 1'b0) begin
                if (last_fall >= 0) begin
                    if (cyc - last_fall > max_per) max_per = cyc - last_fall;
                    if (cyc - last_fall < min_per) min_per = cyc - last_fall;
                end
                last_fall = cyc;
                mon_ok = 1'b1;
                mon_wait(5, mon_ok);
                if (mon_ok && uart_tx_pin !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(10, mon_ok);
                    mon_b[i] = uart_tx_pin;
                end
                mon_wait(10, mon_ok);
                if (mon_ok) begin
                    if (uart_tx_pin !== 1'b1) frame_err++;
                    else rx_q.push_back(mon_b);
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] c);
        @(negedge CLK);
        start = 1'b1;
        word_count = c;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic run_dump(input string name, input logic [15:0] c, input bit extra_start);
        logic [7:0] exp_q [$];
        logic [7:0] sum;
        int budget;
        bit got_done;
        sum = 8'h00;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        for (int i = 0; i < int'(c); i++) begin
            exp_q.push_back(mem[i][7:0]);
            exp_q.push_back(mem[i][15:8]);
            sum = sum + mem[i][7:0] + mem[i][15:8];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        rx_q.delete();
        rd_q.delete();
        done_cnt = 0;
        frame_err = 0;
        last_fall = -1;
        max_per = 0;
        min_per = 1000000;
        pulse_start(c);
        if (extra_start) begin
            repeat (300) @(negedge CLK);
            pulse_start(16'd5);
        end
        budget = (4 + 2 * int'(c)) * 101 + 300;
        got_done = 1'b0;
        for (int i = 0; i < budget && !got_done; i++) begin
            @(negedge CLK);
            if (done_cnt > 0) got_done = 1'b1;
        end
        check_eq({name, " done_seen"}, got_done, 1'b1);
        repeat (3) @(negedge CLK);
        check_eq({name, " done_pulses"}, done_cnt, 1);
        check_eq({name, " busy_after"}, busy, 1'b0);
        check_eq({name, " byte_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
        check_eq({name, " rd_count"}, rd_q.size(), c);
        for (int i = 0; i < rd_q.size() && i < int'(c); i++)
            check_eq($sformatf("%s rd_addr%0d", name, i), rd_q[i], i);
        check_eq({name, " frame_err"}, frame_err, 0);
        if (exp_q.size() > 1) begin
            check_eq({name, " max_frame_period"}, max_per <= 103, 1'b1);
            check_eq({name, " min_frame_period"}, min_per >= 100, 1'b1);
        end
    endtask

    int  bad;
    int  k;
    bit  seen;
    logic exp_bit;
    logic [7:0] pat;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        repeat (2) @(negedge CLK);
        check_eq("reset pin", uart_tx_pin, 1'b1);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset done", done, 1'b0);
        check_eq("reset rd_en", mem_rd_en, 1'b0);
        check_eq("reset addr", mem_addr, 16'h0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        run_dump("two_word", 16'd2, 1'b0);
        run_dump("empty", 16'd0, 1'b0);
        run_dump("start_busy", 16'd2, 1'b1);

        // start in the same cycle as done must not launch a new dump
        pulse_start(16'd1);
        seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check_eq("done_cycle seen", seen, 1'b1);
        start = 1'b1;
        word_count = 16'd3;
        @(negedge CLK);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b0 || uart_tx_pin !== 1'b1) bad++;
            @(negedge CLK);
        end
        check_eq("start_with_done ignored", bad, 0);

        // Bit timing of a 0x55 frame (count LSB of word_count=0x0055)
        pat = 8'h55;
        pulse_start(16'h0055);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (uart_tx_pin === 1'b0) seen = 1'b1;
            else @(negedge CLK);
        end
        check_eq("bit_timing start_seen", seen, 1'b1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i < 10) exp_bit = 1'b0;
            else if (i >= 90) exp_bit = 1'b1;
            else exp_bit = pat[(i / 10) - 1];
            if (uart_tx_pin !== exp_bit) bad++;
            @(negedge CLK);
        end
        check_eq("bit_timing pattern", bad, 0);
        k = 0;
        while (uart_tx_pin !== 1'b0 && k < 10) begin
            @(negedge CLK);
            k++;
        end
        check_eq("bit_timing gap", k <= 3, 1'b1);

        // Reset mid-frame: wait into a data bit, then pull reset between edges
        repeat (35) @(negedge CLK);
        check_eq("pre_reset pin_low", uart_tx_pin, 1'b0);
        #2 RESET = 1'b0;
        #1;
        check_eq("reset_mid pin", uart_tx_pin, 1'b1);
        check_eq("reset_mid busy", busy, 1'b0);
        check_eq("reset_mid rd_en", mem_rd_en, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (uart_tx_pin !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("post_reset idle", bad, 0);
        mem[0] = 16'h00FF;
        run_dump("after_reset", 16'd1, 1'b0);

        // Randomized dumps against the stream model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            run_dump($sformatf("rand%0d", r), 16'($urandom_range(0, 6)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #80_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
